// File: rtl/adder_tree_pkg.sv
// Shared types for the adder-tree term packer: the FILL/OUT state encoding.
package adder_tree_pkg;

   typedef enum logic {
      FILL = 1'b0,
      OUT  = 1'b1
   } pack_state_t;

endpackage

// File: rtl/adder_tree_term_packer.sv
// Packs a stream of terms into fixed-width vectors for a downstream adder tree.
// Unused slots always read zero, so the vector can be summed without masking.
module adder_tree_term_packer
   import adder_tree_pkg::*;
#(
   parameter int NUM_ELEMENTS = 4,
   parameter int BIT_LEN      = 16
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst,
   input  logic                                  i_val,
   input  logic [BIT_LEN-1:0]                    i_dat,
   input  logic                                  i_eop,
   output logic                                  o_rdy,
   output logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]  o_terms,
   output logic [$clog2(NUM_ELEMENTS+1)-1:0]     o_cnt,
   output logic                                  o_eop,
   output logic                                  o_val,
   input  logic                                  i_rdy
);

   localparam int IDX_W = $clog2(NUM_ELEMENTS);
   localparam int CNT_W = $clog2(NUM_ELEMENTS+1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMENTS-1);

   pack_state_t                          state;
   logic [IDX_W-1:0]                     idx;
   logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0] terms;
   logic [CNT_W-1:0]                     cnt;
   logic                                 eop;

   // Handshake: a term moves when i_val && o_rdy at a rising edge; a vector
   // moves when o_val && i_rdy. o_rdy and o_val are mutually exclusive, which
   // gives the one-cycle bubble between consecutive vectors.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= FILL;
         idx   <= '0;
         terms <= '0;
         cnt   <= '0;
         eop   <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (i_val) begin
                  terms[idx] <= i_dat;
                  idx        <= idx + IDX_W'(1);
                  if ((idx == LAST_IDX) || i_eop) begin
                     state <= OUT;
                     cnt   <= CNT_W'(idx) + CNT_W'(1);
                     eop   <= i_eop;
                  end
               end
            end
            OUT: begin
               // Clearing on handoff keeps stale terms out of a short next vector.
               if (i_rdy) begin
                  state <= FILL;
                  idx   <= '0;
                  terms <= '0;
                  cnt   <= '0;
                  eop   <= 1'b0;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

   assign o_rdy   = (state == FILL);
   assign o_val   = (state == OUT);
   assign o_terms = terms;
   assign o_cnt   = cnt;
   assign o_eop   = eop;

endmodule
